// File: rtl/uart_calc_soc.sv
// uart_calc_soc: 8N1 UART calculator, "AAopBB" in, decimal result + CR LF out.
// Build option ECHO_EN: retransmit every byte received while parsing.
module uart_calc_soc #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic clk,
  input  logic resetn,
  input  logic RXD,
  output logic TXD,
  output logic LEDS
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [2:0] S_A1   = 3'd0;
  localparam logic [2:0] S_A2   = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_B1   = 3'd3;
  localparam logic [2:0] S_B2   = 3'd4;
  localparam logic [2:0] S_CALC = 3'd5;
  localparam logic [2:0] S_SEND = 3'd6;

  localparam logic [1:0] P_EVAL = 2'd0;
  localparam logic [1:0] P_DIV  = 2'd1;
  localparam logic [1:0] P_CONV = 2'd2;
  localparam logic [1:0] P_TAIL = 2'd3;

  // ---------------- receiver ----------------
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic [1:0]    rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          rx_valid_q;

  // Two-flop synchronizer plus a delayed copy for falling-edge detect
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= RXD;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // Frame receiver: start re-check at half bit, then mid-bit sampling
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_st_q    <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (rx_st_q)
        R_IDLE: begin
          if (rx_s3_q && !rx_s2_q) begin
            rx_st_q  <= R_START;
            rx_cnt_q <= '0;
          end
        end
        R_START: begin
          if (rx_cnt_q == CNT_MID) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rx_s2_q ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_cnt_q == CNT_END) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_st_q <= R_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        R_STOP: begin
          if (rx_cnt_q == CNT_END) begin
            rx_cnt_q   <= '0;
            rx_valid_q <= rx_s2_q;
            rx_st_q    <= R_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_st_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  logic          tx_busy_q, txd_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [8:0]    tx_sh_q;
  logic          tx_last, tx_ready, tx_req, tx_go;
  logic [7:0]    tx_data;

  assign tx_last  = tx_busy_q && (tx_bit_q == 4'd9)
                 && (tx_cnt_q == CNT_END);
  assign tx_ready = !tx_busy_q || tx_last;
  assign tx_go    = tx_req && tx_ready;

  // Frame transmitter; a new byte loads in the last stop-bit cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_busy_q <= 1'b0;
      txd_q     <= 1'b1;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
    end else if (tx_go) begin
      tx_busy_q <= 1'b1;
      txd_q     <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= {1'b1, tx_data};
    end else if (tx_busy_q) begin
      if (tx_cnt_q == CNT_END) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          txd_q     <= 1'b1;
        end else begin
          txd_q    <= tx_sh_q[0];
          tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
          tx_bit_q <= tx_bit_q + 1'b1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  // ---------------- parser / calculator ----------------
  logic [2:0]  st_q;
  logic [1:0]  ph_q;
  logic [6:0]  a_q, b_q;
  logic [1:0]  op_q;
  logic [13:0] mag_q;
  logic [1:0]  pw_q;
  logic [3:0]  dig_q;
  logic        lead_q, crlf_q;
  logic [6:0]  rem_q, dvd_q;
  logic [5:0]  quo_q;
  logic [2:0]  dcnt_q;
  logic [7:0]  buf_q [0:7];
  logic [2:0]  blen_q, bidx_q;

  logic [7:0]  rb;
  logic [3:0]  dval;
  logic        is_dig, is_ws, is_op;
  logic [1:0]  opc;
  logic        rx_take, recv, bad, err_now;
  logic [13:0] res, pwv;
  logic [7:0]  dv_r;
  logic        dv_ge;
  logic        echo_v;
  logic [7:0]  echo_b;

  function automatic logic [6:0] dec(input logic [3:0] hi,
                                     input logic [3:0] lo);
    return {hi, 3'b000} + {2'b00, hi, 1'b0} + {3'b000, lo};
  endfunction

  assign rb     = rx_sh_q;
  assign dval   = rb[3:0];
  assign is_dig = (rb >= 8'h30) && (rb <= 8'h39);
  assign is_ws  = (rb == 8'h0D) || (rb == 8'h0A) || (rb == 8'h20);

  // Operator byte decode
  always_comb begin
    is_op = 1'b1;
    opc   = 2'd0;
    unique case (rb)
      8'h2B:   opc = 2'd0;
      8'h2D:   opc = 2'd1;
      8'h2A:   opc = 2'd2;
      8'h2F:   opc = 2'd3;
      default: is_op = 1'b0;
    endcase
  end

  assign rx_take = rx_valid_q && (st_q <= S_B2);
  assign recv    = rx_take && !is_ws;
  assign bad     = (st_q == S_OP) ? !is_op : !is_dig;
  assign err_now = (recv && bad)
                || ((st_q == S_CALC) && (ph_q == P_EVAL)
                    && (op_q == 2'd3) && (b_q == 7'd0));

  // Add/sub/mul result, two's complement in 14 bits
  always_comb begin
    res = '0;
    unique case (op_q)
      2'd0:    res = {7'b0, a_q} + {7'b0, b_q};
      2'd1:    res = {7'b0, a_q} - {7'b0, b_q};
      2'd2:    res = {7'b0, a_q} * {7'b0, b_q};
      default: res = '0;
    endcase
  end

  // Decimal place weight for the subtraction formatter
  always_comb begin
    pwv = 14'd1;
    unique case (pw_q)
      2'd0:    pwv = 14'd1000;
      2'd1:    pwv = 14'd100;
      2'd2:    pwv = 14'd10;
      default: pwv = 14'd1;
    endcase
  end

  assign dv_r  = {rem_q, dvd_q[6]};
  assign dv_ge = dv_r >= {1'b0, b_q};

`ifdef ECHO_EN
  logic       echo_v_q;
  logic [7:0] echo_q;

  // One-byte echo slot; it always wins the transmitter over results
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      echo_v_q <= 1'b0;
      echo_q   <= '0;
    end else if (rx_take) begin
      echo_v_q <= 1'b1;
      echo_q   <= rb;
    end else if (tx_go) begin
      echo_v_q <= 1'b0;
    end
  end

  assign echo_v = echo_v_q;
  assign echo_b = echo_q;
`else
  assign echo_v = 1'b0;
  assign echo_b = 8'h00;
`endif

  assign tx_req  = echo_v || ((st_q == S_SEND) && (bidx_q != blen_q));
  assign tx_data = echo_v ? echo_b : buf_q[bidx_q];

  // Parse operands, evaluate, format digits, then stream the buffer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q   <= S_A1;
      ph_q   <= P_EVAL;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      mag_q  <= '0;
      pw_q   <= '0;
      dig_q  <= '0;
      lead_q <= 1'b0;
      crlf_q <= 1'b0;
      rem_q  <= '0;
      dvd_q  <= '0;
      quo_q  <= '0;
      dcnt_q <= '0;
      blen_q <= '0;
      bidx_q <= '0;
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
    end else begin
      unique case (st_q)
        S_A1: if (recv && !bad) begin
          a_q  <= {3'b0, dval};
          st_q <= S_A2;
        end
        S_A2: if (recv && !bad) begin
          a_q  <= dec(a_q[3:0], dval);
          st_q <= S_OP;
        end
        S_OP: if (recv && !bad) begin
          op_q <= opc;
          st_q <= S_B1;
        end
        S_B1: if (recv && !bad) begin
          b_q  <= {3'b0, dval};
          st_q <= S_B2;
        end
        S_B2: if (recv && !bad) begin
          b_q    <= dec(b_q[3:0], dval);
          st_q   <= S_CALC;
          ph_q   <= P_EVAL;
          blen_q <= '0;
          bidx_q <= '0;
          crlf_q <= 1'b0;
        end
        S_CALC: begin
          unique case (ph_q)
            P_EVAL: begin
              pw_q   <= '0;
              dig_q  <= '0;
              lead_q <= 1'b0;
              if (op_q == 2'd3) begin
                ph_q   <= P_DIV;
                dvd_q  <= a_q;
                rem_q  <= '0;
                quo_q  <= '0;
                dcnt_q <= '0;
              end else begin
                mag_q <= res[13] ? -res : res;
                ph_q  <= P_CONV;
                if (res[13]) begin
                  buf_q[0] <= 8'h2D;
                  blen_q   <= 3'd1;
                end
              end
            end
            P_DIV: begin
              rem_q  <= dv_ge ? 7'(dv_r - {1'b0, b_q}) : dv_r[6:0];
              dvd_q  <= {dvd_q[5:0], 1'b0};
              quo_q  <= {quo_q[4:0], dv_ge};
              dcnt_q <= dcnt_q + 1'b1;
              if (dcnt_q == 3'd6) begin
                mag_q <= {7'b0, quo_q, dv_ge};
                ph_q  <= P_CONV;
              end
            end
            P_CONV: begin
              if (pw_q == 2'd3) begin
                buf_q[blen_q] <= {4'h3, mag_q[3:0]};
                blen_q        <= blen_q + 1'b1;
                ph_q          <= P_TAIL;
              end else if (mag_q >= pwv) begin
                mag_q <= mag_q - pwv;
                dig_q <= dig_q + 1'b1;
              end else begin
                if (lead_q || (dig_q != 4'd0)) begin
                  buf_q[blen_q] <= {4'h3, dig_q};
                  blen_q        <= blen_q + 1'b1;
                  lead_q        <= 1'b1;
                end
                dig_q <= '0;
                pw_q  <= pw_q + 1'b1;
              end
            end
            P_TAIL: begin
              buf_q[blen_q] <= crlf_q ? 8'h0A : 8'h0D;
              blen_q        <= blen_q + 1'b1;
              crlf_q        <= 1'b1;
              if (crlf_q) begin
                st_q   <= S_SEND;
                bidx_q <= '0;
              end
            end
            default: ph_q <= P_EVAL;
          endcase
        end
        S_SEND: begin
          if (tx_go && !echo_v) bidx_q <= bidx_q + 1'b1;
          if ((bidx_q == blen_q) && !tx_busy_q && !echo_v)
            st_q <= S_A1;
        end
        default: st_q <= S_A1;
      endcase
      if (err_now) begin
        buf_q[0] <= 8'h45;
        buf_q[1] <= 8'h52;
        buf_q[2] <= 8'h52;
        buf_q[3] <= 8'h0D;
        buf_q[4] <= 8'h0A;
        blen_q   <= 3'd5;
        bidx_q   <= '0;
        st_q     <= S_SEND;
      end
    end
  end

  assign TXD  = txd_q;
  assign LEDS = (st_q != S_A1);

endmodule

// File: tb/tb_uart_calc_soc.sv
// tb_uart_calc_soc: directed bench for uart_calc_soc.
// Short bit period; TXD decoded by a monitor into a byte queue.
module tb_uart_calc_soc;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic RXD = 1'b1;
  logic TXD;
  logic LEDS;

  int checks = 0;
  int failures = 0;
  byte unsigned rxq[$];

  uart_calc_soc #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .resetn(resetn),
    .RXD   (RXD),
    .TXD   (TXD),
    .LEDS  (LEDS)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // TXD monitor: mid-bit sampling, pushes each byte at mid stop bit
  initial begin
    byte unsigned mb;
    forever begin
      @(negedge clk);
      if (resetn && TXD === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        if (TXD === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            mb[i] = TXD;
          end
          repeat (CPB) @(negedge clk);
          check("tx_stop", int'(TXD), 1);
          rxq.push_back(mb);
        end
      end
    end
  end

  task automatic send_byte(input byte unsigned b, input bit stop);
    RXD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(negedge clk);
    end
    RXD = stop;
    repeat (CPB) @(negedge clk);
    RXD = 1'b1;
  endtask

  task automatic run_case(input string in, input string dig);
    int n;
    int w;
    byte unsigned exp;
    rxq.delete();
    for (int i = 0; i < in.len(); i++) begin
      send_byte(in[i], 1'b1);
      if (i == 0) check({in, " led_busy"}, int'(LEDS), 1);
      if (i < in.len() - 1) repeat (2 * CPB) @(negedge clk);
    end
    w = 0;
    while (TXD === 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({in, " start<=64"}, int'(w <= 64), 1);
    n = dig.len() + 2;
    w = 0;
    while (rxq.size() < n && w < 300 * CPB) begin
      @(negedge clk);
      w++;
    end
    check({in, " len"}, rxq.size(), n);
    check({in, " led_last"}, int'(LEDS), 1);
    for (int i = 0; i < n; i++) begin
      if (i < dig.len()) exp = dig[i];
      else if (i == dig.len()) exp = 8'h0D;
      else exp = 8'h0A;
      check($sformatf("%s byte%0d", in, i),
            (i < rxq.size()) ? int'(rxq[i]) : -1, int'(exp));
    end
    repeat (CPB) @(negedge clk);
    check({in, " led_idle"}, int'(LEDS), 0);
  endtask

  initial begin
    int w;
    resetn = 1'b0;
    RXD = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_txd", int'(TXD), 1);
    check("rst_led", int'(LEDS), 0);
    resetn = 1'b1;
    repeat (2000) @(negedge clk);
    check("idle_nobytes", rxq.size(), 0);
    check("idle_txd", int'(TXD), 1);
    check("idle_led", int'(LEDS), 0);

    RXD = 1'b0;
    repeat (4) @(negedge clk);
    RXD = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    check("glitch_nobytes", rxq.size(), 0);
    check("glitch_led", int'(LEDS), 0);

    send_byte(8'h35, 1'b0);
    repeat (4 * CPB) @(negedge clk);
    check("frame_err_led", int'(LEDS), 0);
    check("frame_err_nobytes", rxq.size(), 0);

    run_case("45*42", "1890");
    run_case("99*03", "297");
    run_case("99/03", "33");
    run_case("12/00", "ERR");
    run_case("03-45", "-42");
    run_case("00+00", "0");
    run_case("4x", "ERR");
    run_case("10+05", "15");
    run_case("12 + 34", "46");
    run_case("00-99", "-99");
    run_case("99+99", "198");
    run_case("99/07", "14");
    run_case("07/99", "0");

    rxq.delete();
    for (int i = 0; i < 5; i++) begin
      string s;
      s = "45*42";
      send_byte(s[i], 1'b1);
      if (i < 4) repeat (2 * CPB) @(negedge clk);
    end
    w = 0;
    while (TXD === 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("midtx_started", int'(TXD), 0);
    repeat (3 * CPB) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midtx_rst_txd", int'(TXD), 1);
    check("midtx_rst_led", int'(LEDS), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (15 * CPB) @(negedge clk);
    rxq.delete();
    repeat (20 * CPB) @(negedge clk);
    check("midtx_quiet", rxq.size(), 0);
    check("midtx_led", int'(LEDS), 0);
    run_case("00+00", "0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_calc_soc.md
Name: uart_calc_soc

Overview:
- Self-contained UART calculator SoC for the iCE40-HX8K breakout, running from a 12 MHz clock.
- Receives ASCII expressions over 8N1 serial at 9600 baud.
- Each expression is two 2-digit decimal operands separated by an operator. The block evaluates it and transmits the decimal result followed by CR LF.
- Sits at the top level between the board pins (RXD/TXD, LED) and the clock/reset.

Parameters:
- CLKS_PER_BIT, 1250, clock cycles per UART bit (12e6/9600).

Ports:
- clk  input  1  system clock, 12 MHz, rising-edge.
- resetn  input  1  asynchronous active-low reset.
- RXD  input  1  UART receive line; idle high.
- TXD  output  1  UART transmit line; idle high.
- LEDS  output  1  LEDS[0] = busy indicator.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on resetn. While resetn=0:
  - TXD=1, LEDS=0.
  - All FSMs go to IDLE and operand/result registers clear.
  - Reset mid-frame aborts RX/TX immediately. TXD returns high.
- RX path:
  - RXD passes through a 2-flop synchronizer.
  - A falling edge in IDLE starts a frame. The start bit is re-checked at CLKS_PER_BIT/2; if RXD is high it is a glitch and the receiver returns to IDLE.
  - Data bits are sampled every CLKS_PER_BIT, LSB first. The stop bit is sampled one bit later.
  - Stop=1: issue a 1-cycle rx_valid with the byte. Stop=0 (framing error): discard the byte with no rx_valid.
  - The receiver re-arms in the stop-bit sample cycle.
- Parser FSM states: A1, A2, OP, B1, B2, CALC, SEND.
  - A1/A2/B1/B2 accept only '0'..'9' (0x30-0x39). Each operand = 10*first digit + second digit, range 0..99.
  - OP accepts '+' (0x2B), '-' (0x2D), '*' (0x2A), '/' (0x2F).
  - CR (0x0D), LF (0x0A) and space (0x20) are ignored in every receiving state.
  - Any other byte in a receiving state forces the result to ERR and goes to SEND.
  - Bytes arriving during CALC/SEND are dropped.
- Arithmetic (14-bit signed internal):
  - '+': result 0..198.
  - '-': A-B, range -99..99.
  - '*': result 0..9801.
  - '/': floor(A/B) via iterative restoring division, at most 8 cycles. B=0 gives ERR.
- Output:
  - Result is converted to decimal (double-dabble or repeated subtraction) with no leading zeros; zero prints as "0". A negative result gets a leading '-'.
  - Transmitted sequence is the result digits then 0x0D 0x0A. ERR transmits "ERR" then 0x0D 0x0A.
  - The first TX start bit begins within 64 clocks after the rx_valid of the B2 digit.
  - TX frames are back-to-back: start(0), 8 data LSB first, stop(1), each bit CLKS_PER_BIT clocks. The next start bit follows immediately after the stop bit.
  - After the final LF stop bit the FSM returns to A1.
- LEDS[0]:
  - Is 1 in every state except A1, i.e. from acceptance of the first operand digit until the final stop bit completes.
  - Returns to 0 after an ERR transmission completes.
- Simultaneous events: rx_valid coinciding with the CALC→SEND transition is dropped.

Optional Feature:
- ECHO_EN defined: every byte received in a receiving state (A1..B2, including ignored whitespace) is retransmitted on TXD before the next byte is processed.
  - Echo completes before the result starts.
  - A one-byte TX request queue arbitrates echo versus result; echo has priority.
- ECHO_EN undefined: TXD carries only results and ERR.

Test Plan:
- Reset: hold resetn=0 for 8 clocks, RXD=1 → TXD=1, LEDS=0. Release; nothing transmits for 50000 clocks.
- "4","5","*","4","2" sent at 9600 baud with 2500-clock gaps → TXD emits 0x31 0x38 0x39 0x30 0x0D 0x0A ("1890\r\n"). LEDS=1 from the '4' until the final stop bit, then 0.
- "9","9","*","0","3" → "297\r\n". "9","9","/","0","3" → "33\r\n".
- "1","2","/","0","0" → "ERR\r\n". "0","3","-","4","5" → "-42\r\n". "0","0","+","0","0" → "0\r\n".
- "4","x" → "ERR\r\n" immediately after 'x'. A following "10+05" → "15\r\n" (parser resynchronised).
- A 300-clock low glitch on RXD produces no byte. A frame with stop bit = 0 is discarded. resetn pulsed low mid-TX → TXD high at once, parser back in A1.
